// File: rtl/ajuste_tiempo_bcd_pkg.sv
// Shared definitions for the user time-edit stage:
// FSM states, cursor field codes and BCD limits.
package ajuste_tiempo_bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CARGA = 2'd1,
        EDIT  = 2'd2
    } estado_t;

    localparam logic [1:0] CAMPO_SEG  = 2'd0;
    localparam logic [1:0] CAMPO_MIN  = 2'd1;
    localparam logic [1:0] CAMPO_HORA = 2'd2;

    localparam logic [7:0] LIM_SEG  = 8'h59;
    localparam logic [7:0] LIM_MIN  = 8'h59;
    localparam logic [7:0] LIM_HORA = 8'h23;

    // Both nibbles decimal and the value within 00..lim.
    function automatic logic bcd_valido(
        input logic [7:0] v,
        input logic [7:0] lim
    );
        return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v <= lim);
    endfunction

endpackage

// File: rtl/ajuste_tiempo_bcd_contador.sv
// One editable BCD field: snapshot load with validation,
// wrap-around increment/decrement and a change flag.
module contador_bcd_campo
    import ajuste_tiempo_bcd_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] valor_carga,
    input  logic       inc,
    input  logic       dec,
    input  logic [7:0] max,
    output logic [7:0] valor,
    output logic       cambio
);

    logic [7:0] siguiente;

    always_comb begin
        siguiente = valor;
        if (load) begin
            siguiente = bcd_valido(valor_carga, max) ? valor_carga : 8'h00;
        end else if (inc && !dec) begin
            if (valor == max)
                siguiente = 8'h00;
            else if (valor[3:0] == 4'd9)
                siguiente = {valor[7:4] + 4'd1, 4'd0};
            else
                siguiente = {valor[7:4], valor[3:0] + 4'd1};
        end else if (dec && !inc) begin
            if (valor == 8'h00)
                siguiente = max;
            else if (valor[3:0] == 4'd0)
                siguiente = {valor[7:4] - 4'd1, 4'd9};
            else
                siguiente = {valor[7:4], valor[3:0] - 4'd1};
        end
    end

    // A load always strobes so the display shows the snapshot.
    assign cambio = load || (siguiente != valor);

    always_ff @(posedge clk) begin
        if (reset)
            valor <= 8'h00;
        else
            valor <= siguiente;
    end

endmodule

// File: rtl/ajuste_tiempo_bcd.sv
// User time-edit stage: snapshots the RTC, lets the user step
// each BCD field and strobes the display registers on change.
module ajuste_tiempo_bcd
    import ajuste_tiempo_bcd_pkg::*;
#(
    parameter logic [7:0] MAX_SEG  = LIM_SEG,
    parameter logic [7:0] MAX_MIN  = LIM_MIN,
    parameter logic [7:0] MAX_HORA = LIM_HORA
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       seleccion,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_next,
    input  logic [7:0] seg_rtc,
    input  logic [7:0] min_rtc,
    input  logic [7:0] hora_rtc,
    output logic [7:0] dseg,
    output logic [7:0] dmin,
    output logic [7:0] dhora,
    output logic       ACT_seg,
    output logic       ACT_min,
    output logic       ACT_hora,
    output logic [1:0] campo
);

    estado_t estado, estado_sig;

    logic cargar, editar;
    logic inc_seg, dec_seg, inc_min, dec_min, inc_hora, dec_hora;
    logic cambio_seg, cambio_min, cambio_hora;

    always_ff @(posedge clk) begin
        if (reset)
            estado <= IDLE;
        else
            estado <= estado_sig;
    end

    always_comb begin
        estado_sig = estado;
        cargar     = 1'b0;
        editar     = 1'b0;
        unique case (estado)
            IDLE: begin
                if (seleccion)
                    estado_sig = CARGA;
            end
            CARGA: begin
                cargar     = 1'b1;
                estado_sig = seleccion ? EDIT : IDLE;
            end
            EDIT: begin
                if (seleccion)
                    editar = 1'b1;
                else
                    estado_sig = IDLE;
            end
            default: estado_sig = IDLE;
        endcase
    end

    // Steps go to the field selected before any cursor move.
    always_comb begin
        inc_seg  = editar && btn_up   && (campo == CAMPO_SEG);
        dec_seg  = editar && btn_down && (campo == CAMPO_SEG);
        inc_min  = editar && btn_up   && (campo == CAMPO_MIN);
        dec_min  = editar && btn_down && (campo == CAMPO_MIN);
        inc_hora = editar && btn_up   && (campo == CAMPO_HORA);
        dec_hora = editar && btn_down && (campo == CAMPO_HORA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            campo <= CAMPO_SEG;
        end else if (cargar) begin
            campo <= CAMPO_SEG;
        end else if (editar && btn_next) begin
            campo <= (campo == CAMPO_HORA) ? CAMPO_SEG : campo + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ACT_seg  <= 1'b0;
            ACT_min  <= 1'b0;
            ACT_hora <= 1'b0;
        end else begin
            ACT_seg  <= cambio_seg;
            ACT_min  <= cambio_min;
            ACT_hora <= cambio_hora;
        end
    end

    contador_bcd_campo u_seg (
        .clk         (clk),
        .reset       (reset),
        .load        (cargar),
        .valor_carga (seg_rtc),
        .inc         (inc_seg),
        .dec         (dec_seg),
        .max         (MAX_SEG),
        .valor       (dseg),
        .cambio      (cambio_seg)
    );

    contador_bcd_campo u_min (
        .clk         (clk),
        .reset       (reset),
        .load        (cargar),
        .valor_carga (min_rtc),
        .inc         (inc_min),
        .dec         (dec_min),
        .max         (MAX_MIN),
        .valor       (dmin),
        .cambio      (cambio_min)
    );

    contador_bcd_campo u_hora (
        .clk         (clk),
        .reset       (reset),
        .load        (cargar),
        .valor_carga (hora_rtc),
        .inc         (inc_hora),
        .dec         (dec_hora),
        .max         (MAX_HORA),
        .valor       (dhora),
        .cambio      (cambio_hora)
    );

endmodule
